inter_packet_delay_meter: RTL
=============================

INTER_PACKET_DELAY_METER -- requirements
Module: inter_packet_delay_meter

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, slave/master stream data width.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, slave/master stream tuser width.
REQ-003 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, width of the delay field, counter and statistics.
REQ-004 SHALL have parameter C_DELAY_POS, default 32, lowest tuser bit of the delay field.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 axi_aclk  in  1  sole clock; all logic on its rising edge.
REQ-007 axi_areset  in  1  asynchronous active-high reset.
REQ-008 s_axis_tdata/tstrb/tuser/tvalid/tlast  in  per parameters  ingress stream; s_axis_tready  out  1.
REQ-009 m_axis_tdata/tstrb/tuser/tvalid/tlast  out  per parameters  egress stream; m_axis_tready  in  1.
REQ-010 sw_rst  in  1  synchronous software clear of counter, first-packet flag and statistics.
REQ-011 ipd_en  in  1  measurement enable; 0 means transparent pass-through.
REQ-012 delay_min, delay_max, pkt_count  out  C_S_AXI_DATA_WIDTH each  gap statistics.

Function
REQ-013 SHALL use a single output register stage: s_axis_tready = !m_axis_tvalid || m_axis_tready; latency exactly 1 cycle; no bubbles under continuous ready.
REQ-014 SHALL track SOP with in_pkt flag: beat accepted while in_pkt=0 is SOP; in_pkt sets on accepted non-tlast beat, clears on accepted tlast beat; single-beat packets keep in_pkt=0.
REQ-015 gap counter SHALL increment every cycle while ipd_en=1, saturating at all-ones (no wrap).
REQ-016 on SOP acceptance with ipd_en=1, captured delay SHALL equal counter value (cycles between consecutive SOP handshakes); counter reloads to 1 that same edge.
REQ-017 first SOP after reset, sw_rst or ipd_en rising SHALL carry delay 0 and SHALL not update statistics.
REQ-018 SOP beat SHALL leave with tuser[C_DELAY_POS +: C_S_AXI_DATA_WIDTH] replaced by captured delay; all other tuser bits, and all non-SOP beats, unchanged.
REQ-019 ipd_en=0: counter held at 0, first-packet flag set, tuser unmodified, statistics frozen.
REQ-020 sw_rst=1 coincident with SOP acceptance: sw_rst wins; beat forwarded with delay 0; counter reloads to 1; first-packet flag cleared.
REQ-021 backpressure: counter keeps running while stalled; delay measured at handshake, not at tvalid.
REQ-022 delay_min SHALL track smallest, delay_max largest, pkt_count number of measured (non-first) gaps; pkt_count saturates.

Reset
REQ-023 axi_areset SHALL force m_axis_tvalid=0, in_pkt=0, counter=0, first-packet flag=1, delay_min=all-ones, delay_max=0, pkt_count=0; m_axis data/tuser/tstrb/tlast=0.
REQ-024 reset mid-packet SHALL drop buffered beat; next accepted beat is SOP.

Configuration
REQ-025 macro IPD_METER_STATS_EN defined: statistics logic per REQ-022 compiled in.
REQ-026 macro IPD_METER_STATS_EN undefined: no statistics registers; delay_min, delay_max, pkt_count tied to 0; stamping unaffected.

Structure
REQ-027 shared package inter_packet_delay_pkg SHALL hold delay field width/position defaults and the counter saturation constant, shared with the generator-side delay block.
REQ-028 one sub-module ipd_gap_counter SHALL hold counter, first-packet flag and saturation; stream register and statistics stay in top.

Verification
REQ-029 ipd_en=1, three 1-beat packets at cycles 10, 15, 115, ready=1 -> stamped delays 0, 5, 100; min 5, max 100, count 2.
REQ-030 4-beat packet then SOP 20 cycles after first SOP -> only SOP beats modified; non-SOP tuser bit-identical.
REQ-031 ipd_en=0, tuser field 0xDEADBEEF -> output field 0xDEADBEEF, counters/stats unchanged.
REQ-032 m_axis_tready low 7 cycles around second SOP issued 3 cycles after first -> stamped delay 10, no beat lost or duplicated.
REQ-033 idle 2^32+5 cycles (C_S_AXI_DATA_WIDTH reduced to 8 in bench: 300 cycles) -> delay 0xFF saturated.
REQ-034 axi_areset asserted mid-packet then released -> m_axis_tvalid 0 next edge; next packet stamped 0; delay_min all-ones.

Source files
------------

// File: rtl/inter_packet_delay_pkg.sv
// Shared constants for the inter-packet delay field.
// Used by the meter and by the generator-side delay block so both agree on
// where the delay lives in tuser and how the gap counter saturates.
package inter_packet_delay_pkg;

   // Default width and lowest tuser bit of the delay field.
   localparam int DELAY_W_DEFAULT   = 32;
   localparam int DELAY_POS_DEFAULT = 32;

   // Saturation fill bit: the gap counter stops at this bit replicated
   // across its whole width (all-ones), so long idles never wrap to a
   // small, misleading delay.
   localparam logic CNT_SAT_BIT = 1'b1;

endpackage

// File: rtl/inter_packet_delay_meter_gap_counter.sv
// Gap counter for the inter-packet delay meter.
// Counts cycles between consecutive SOP handshakes, saturating at all-ones,
// and tracks whether the next SOP is the first one after reset, software
// clear or enable rising (such an SOP carries no meaningful gap).
module ipd_gap_counter
   import inter_packet_delay_pkg::*;
#(
   parameter int W = DELAY_W_DEFAULT
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         sw_rst,
   input  logic         ipd_en,
   input  logic         sop_fire,
   output logic [W-1:0] cnt,
   output logic         first_pkt
);

   localparam logic [W-1:0] CNT_SAT = {W{CNT_SAT_BIT}};

   // Counter and first-packet flag; an SOP handshake outranks sw_rst so the
   // SOP that coincides with a clear becomes the reference for the next gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         first_pkt <= 1'b1;
      end else if (!ipd_en) begin
         cnt       <= '0;
         first_pkt <= 1'b1;
      end else if (sop_fire) begin
         cnt       <= W'(1);
         first_pkt <= 1'b0;
      end else if (sw_rst) begin
         cnt       <= '0;
         first_pkt <= 1'b1;
      end else if (cnt != CNT_SAT) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/inter_packet_delay_meter.sv
// Inter-packet delay meter.
// Passes an AXI stream through one register stage and, while ipd_en is set,
// overwrites the delay field of every SOP beat's tuser with the number of
// cycles since the previous SOP handshake. Optional gap statistics
// (min/max/count) are built only when IPD_METER_STATS_EN is defined;
// otherwise the statistics outputs are tied to zero.
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. The output stage accepts a new beat whenever it is empty or its
// current beat is leaving in the same cycle, so there are no bubbles under
// continuous m_axis_tready, and tvalid/payload stay stable while stalled.
module inter_packet_delay_meter
   import inter_packet_delay_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXI_DATA_WIDTH   = DELAY_W_DEFAULT,
   parameter int C_DELAY_POS          = DELAY_POS_DEFAULT
)(
   input  logic                              axi_aclk,
   input  logic                              axi_areset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   input  logic                              sw_rst,
   input  logic                              ipd_en,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     delay_min,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     delay_max,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     pkt_count
);

   localparam int AW = C_S_AXI_DATA_WIDTH;

   logic                            in_pkt;
   logic                            s_fire;
   logic                            sop_fire;
   logic                            first_pkt;
   logic [AW-1:0]                   gap_cnt;
   logic [AW-1:0]                   delay;
   logic [C_S_AXIS_TUSER_WIDTH-1:0] stamped_tuser;

   assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
   assign s_fire        = s_axis_tvalid && s_axis_tready;
   assign sop_fire      = s_fire && !in_pkt;

   // The first SOP of a measurement window, or one coinciding with a clear,
   // has no valid predecessor and reports zero.
   assign delay = (first_pkt || sw_rst) ? '0 : gap_cnt;

   ipd_gap_counter #(
      .W (AW)
   ) u_gap_counter (
      .clk       (axi_aclk),
      .rst       (axi_areset),
      .sw_rst    (sw_rst),
      .ipd_en    (ipd_en),
      .sop_fire  (sop_fire),
      .cnt       (gap_cnt),
      .first_pkt (first_pkt)
   );

   // Packet boundary tracking: the first beat accepted outside a packet is SOP.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         in_pkt <= 1'b0;
      end else if (s_fire) begin
         in_pkt <= !s_axis_tlast;
      end
   end

   // Replace only the delay field, and only on measured SOP beats.
   always_comb begin
      stamped_tuser = s_axis_tuser;
      if (sop_fire && ipd_en) begin
         stamped_tuser[C_DELAY_POS +: AW] = delay;
      end
   end

   // Single output register stage.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tstrb  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
      end else begin
         if (s_axis_tready) begin
            m_axis_tvalid <= s_axis_tvalid;
         end
         if (s_fire) begin
            m_axis_tdata <= s_axis_tdata;
            m_axis_tstrb <= s_axis_tstrb;
            m_axis_tuser <= stamped_tuser;
            m_axis_tlast <= s_axis_tlast;
         end
      end
   end

`ifdef IPD_METER_STATS_EN
   logic measured;

   assign measured = sop_fire && ipd_en && !first_pkt && !sw_rst;

   // Gap statistics; a software clear wins over a coincident measurement.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         delay_min <= '1;
         delay_max <= '0;
         pkt_count <= '0;
      end else if (sw_rst) begin
         delay_min <= '1;
         delay_max <= '0;
         pkt_count <= '0;
      end else if (measured) begin
         if (delay < delay_min) delay_min <= delay;
         if (delay > delay_max) delay_max <= delay;
         if (pkt_count != '1)   pkt_count <= pkt_count + AW'(1);
      end
   end
`else
   assign delay_min = '0;
   assign delay_max = '0;
   assign pkt_count = '0;
`endif

endmodule
